// File: rtl/bip_sel_mux_pipe_pkg.sv
// Shared definitions for the BIP datapath blocks.
//   BIP_WORD_W    default operand word width
//   BIP_ERRCNT_W  width of the illegal-select counter
//   pipe_depth_ok / sel_width_ok  parameter range checks used at elaboration
//   errcnt_inc    saturating increment for the error counter
package bip_sel_mux_pipe_pkg;

  localparam int BIP_WORD_W   = 16;
  localparam int BIP_ERRCNT_W = 8;

  localparam logic [BIP_ERRCNT_W-1:0] ERRCNT_MAX = '1;

  function automatic bit pipe_depth_ok(input int pipe);
    return (pipe >= 1) && (pipe <= 4);
  endfunction

  function automatic bit sel_width_ok(input int sel_w, input int num_in);
    return (num_in >= 2) && (num_in <= 16) && (sel_w >= 1) && ((1 << sel_w) >= num_in);
  endfunction

  function automatic logic [BIP_ERRCNT_W-1:0] errcnt_inc(input logic [BIP_ERRCNT_W-1:0] c);
    return (c == ERRCNT_MAX) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/bip_pipe_stage.sv
// One valid/ready register slice.
//   clk, reset  clock and synchronous active-high reset
//   in_valid_i  beat offered by the previous slice (or the select logic)
//   in_data_i   beat payload
//   ready_i     the next slice (or downstream) accepts this slice's beat
//   valid_o     this slice holds a beat
//   data_o      payload of the held beat
// The matching upstream ready (!valid_o || ready_i) is formed by the parent so
// the whole ready chain lives in one combinational process.
module bip_pipe_stage #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid_i,
  input  logic [W-1:0] in_data_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  logic         load;

  assign load = !valid_q || ready_i;

  // Payload only moves on a real beat, so an emptied slice keeps its last word.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = in_valid_i;
      if (in_valid_i) data_d = in_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/bip_sel_mux_pipe.sv
// N:1 operand word selector with a PIPE-deep valid/ready register pipeline.
//   clk, reset   clock and synchronous active-high reset
//   in_bus       NUM_IN flattened words, word k = in_bus[k*WIDTH +: WIDTH]
//   sel          word index, sampled with in_valid
//   in_valid     upstream beat present
//   in_ready     beat accepted this cycle (combinational from out_ready)
//   out_data     selected word (zero for an illegal select)
//   out_err      the beat carried sel >= NUM_IN
//   out_valid    out_data/out_err valid
//   out_ready    downstream accepts
//   err_clr      clears err_sticky and err_cnt (an illegal accept in the same cycle wins)
//   err_sticky   set by any accepted illegal beat
//   err_cnt      saturating count of accepted illegal beats
module bip_sel_mux_pipe
  import bip_sel_mux_pipe_pkg::*;
#(
  parameter int WIDTH  = BIP_WORD_W,
  parameter int NUM_IN = 3,
  parameter int SEL_W  = 2,
  parameter int PIPE   = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_bus,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_err,
  output logic                    out_valid,
  input  logic                    out_ready,
  input  logic                    err_clr,
  output logic                    err_sticky,
  output logic [BIP_ERRCNT_W-1:0] err_cnt
);

  if (!pipe_depth_ok(PIPE) || !sel_width_ok(SEL_W, NUM_IN)) begin : g_bad_params
    $error("bip_sel_mux_pipe: PIPE must be 1..4, NUM_IN 2..16 and 2**SEL_W >= NUM_IN");
  end

  // vld[k]/beat[k] feed stage k; vld[PIPE]/beat[PIPE] is the last stage's output.
  // rdy[k] is "stage k may load"; rdy[PIPE] is the downstream ready.
  logic [PIPE:0]            vld;
  logic [PIPE:0][WIDTH:0]   beat;
  logic [PIPE:0]            rdy;

  logic [WIDTH-1:0]         sel_data;
  logic                     sel_err;
  logic                     illegal_acc;

  logic                     sticky_q, sticky_d;
  logic [BIP_ERRCNT_W-1:0]  cnt_q, cnt_d;

  // Select/decode into stage 0; an unmatched index is the illegal case.
  always_comb begin
    sel_data = '0;
    sel_err  = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        sel_data = in_bus[k*WIDTH +: WIDTH];
        sel_err  = 1'b0;
      end
    end
  end

  assign vld[0]  = in_valid;
  assign beat[0] = {sel_err, sel_data};

  // Ready ripples back from out_ready so a full pipe with a draining head still accepts.
  always_comb begin
    rdy       = '0;
    rdy[PIPE] = out_ready;
    for (int k = PIPE - 1; k >= 0; k--) begin
      rdy[k] = !vld[k+1] || rdy[k+1];
    end
  end

  assign in_ready = rdy[0];

  for (genvar k = 0; k < PIPE; k++) begin : g_stage
    bip_pipe_stage #(
      .W(WIDTH + 1)
    ) u_stage (
      .clk        (clk),
      .reset      (reset),
      .in_valid_i (vld[k]),
      .in_data_i  (beat[k]),
      .ready_i    (rdy[k+1]),
      .valid_o    (vld[k+1]),
      .data_o     (beat[k+1])
    );
  end

  assign out_valid = vld[PIPE];
  assign out_data  = beat[PIPE][WIDTH-1:0];
  assign out_err   = beat[PIPE][WIDTH];

  // Error bookkeeping at stage 0 acceptance; a same-cycle clear restarts the count at 1.
  assign illegal_acc = in_valid && rdy[0] && sel_err;

  always_comb begin
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    if (illegal_acc) begin
      sticky_d = 1'b1;
      cnt_d    = err_clr ? BIP_ERRCNT_W'(1) : errcnt_inc(cnt_q);
    end else if (err_clr) begin
      sticky_d = 1'b0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign err_sticky = sticky_q;
  assign err_cnt    = cnt_q;

endmodule

// File: tb/tb_bip_sel_mux_pipe.sv
module tb_bip_sel_mux_pipe;

  typedef struct {
    logic [31:0] d;
    logic        e;
    int          stamp;
  } exp_t;

  typedef struct {
    logic [1:0]  sel;
    logic [15:0] d;
    logic        e;
    logic [7:0]  cnt;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // DUT1: PIPE=1, 3 x 16-bit inputs
  logic         rst1, iv1, or1, clr1, in_ready1, out_valid1, out_err1, sticky1;
  logic [1:0]   sel1;
  logic [47:0]  bus1;
  logic [15:0]  od1;
  logic [7:0]   cnt1;
  // DUT2: PIPE=2, 3 x 16-bit inputs
  logic         rst2, iv2, or2, clr2, in_ready2, out_valid2, out_err2, sticky2;
  logic [1:0]   sel2;
  logic [47:0]  bus2;
  logic [15:0]  od2;
  logic [7:0]   cnt2;
  // DUT3: PIPE=3, 5 x 32-bit inputs
  logic         rst3, iv3, or3, clr3, in_ready3, out_valid3, out_err3, sticky3;
  logic [2:0]   sel3;
  logic [159:0] bus3;
  logic [31:0]  od3;
  logic [7:0]   cnt3;

  bip_sel_mux_pipe #(.WIDTH(16), .NUM_IN(3), .SEL_W(2), .PIPE(1)) dut1 (
    .clk(clk), .reset(rst1), .in_bus(bus1), .sel(sel1), .in_valid(iv1),
    .in_ready(in_ready1), .out_data(od1), .out_err(out_err1), .out_valid(out_valid1),
    .out_ready(or1), .err_clr(clr1), .err_sticky(sticky1), .err_cnt(cnt1));

  bip_sel_mux_pipe #(.WIDTH(16), .NUM_IN(3), .SEL_W(2), .PIPE(2)) dut2 (
    .clk(clk), .reset(rst2), .in_bus(bus2), .sel(sel2), .in_valid(iv2),
    .in_ready(in_ready2), .out_data(od2), .out_err(out_err2), .out_valid(out_valid2),
    .out_ready(or2), .err_clr(clr2), .err_sticky(sticky2), .err_cnt(cnt2));

  bip_sel_mux_pipe #(.WIDTH(32), .NUM_IN(5), .SEL_W(3), .PIPE(3)) dut3 (
    .clk(clk), .reset(rst3), .in_bus(bus3), .sel(sel3), .in_valid(iv3),
    .in_ready(in_ready3), .out_data(od3), .out_err(out_err3), .out_valid(out_valid3),
    .out_ready(or3), .err_clr(clr3), .err_sticky(sticky3), .err_cnt(cnt3));

  // Scoreboard state, one slot per DUT
  exp_t        sbq[3][$];
  bit          stall[3];
  logic [31:0] hold_d[3];
  logic        hold_e[3];
  int          n_out[3];
  bit          lat_on[3];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic logic [32:0] model(input logic [159:0] bus, input int s, input int n,
                                        input int w);
    logic [31:0] m;
    if (s >= n) return {1'b1, 32'h0};
    m = bus[s*w +: 32];
    if (w < 32) m = m & ((32'h1 << w) - 32'h1);
    return {1'b0, m};
  endfunction

  // Called on every falling edge: pop/compare an outgoing beat, push an accepted one,
  // and check that a stalled output stays put.
  task automatic mon(input int id, input logic rst, input logic iv, input logic ir,
                     input logic ov, input logic ordy, input logic [31:0] od,
                     input logic oe, input logic [32:0] expv, input int pipe);
    exp_t e;
    if (rst) begin
      sbq[id].delete();
      stall[id] = 1'b0;
      return;
    end
    if (stall[id]) begin
      chk($sformatf("dut%0d_stall_valid", id + 1), 32'(ov), 32'd1);
      chk($sformatf("dut%0d_stall_data", id + 1), od, hold_d[id]);
      chk($sformatf("dut%0d_stall_err", id + 1), 32'(oe), 32'(hold_e[id]));
    end
    if (ov && ordy) begin
      chk($sformatf("dut%0d_beat_expected", id + 1), 32'(sbq[id].size() != 0), 32'd1);
      if (sbq[id].size() != 0) begin
        e = sbq[id].pop_front();
        chk($sformatf("dut%0d_out_data", id + 1), od, e.d);
        chk($sformatf("dut%0d_out_err", id + 1), 32'(oe), 32'(e.e));
        if (lat_on[id]) chk($sformatf("dut%0d_latency", id + 1), 32'(cyc - e.stamp), 32'(pipe));
      end
      n_out[id]++;
    end
    if (iv && ir) sbq[id].push_back('{d: expv[31:0], e: expv[32], stamp: cyc});
    stall[id]  = ov && !ordy;
    hold_d[id] = od;
    hold_e[id] = oe;
  endtask

  always @(negedge clk)
    mon(0, rst1, iv1, in_ready1, out_valid1, or1, 32'(od1), out_err1,
        model(160'(bus1), int'(sel1), 3, 16), 1);
  always @(negedge clk)
    mon(1, rst2, iv2, in_ready2, out_valid2, or2, 32'(od2), out_err2,
        model(160'(bus2), int'(sel2), 3, 16), 2);
  always @(negedge clk)
    mon(2, rst3, iv3, in_ready3, out_valid3, or3, od3, out_err3,
        model(bus3, int'(sel3), 5, 32), 3);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send2(input logic [1:0] s);
    logic acc;
    acc = 1'b0;
    iv2 = 1'b1;
    sel2 = s;
    for (int n = 0; n < 20 && !acc; n++) begin
      @(negedge clk);
      acc = in_ready2;
      @(posedge clk);
      #1;
    end
    iv2 = 1'b0;
    chk("dut2_send_accepted", 32'(acc), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t vt[6];
  int   base;

  initial begin
    rst1 = 1; rst2 = 1; rst3 = 1;
    iv1 = 0; iv2 = 0; iv3 = 0;
    or1 = 1; or2 = 1; or3 = 0;
    clr1 = 0; clr2 = 0; clr3 = 0;
    sel1 = 0; sel2 = 0; sel3 = 0;
    bus1 = {16'h0003, 16'h0002, 16'h0001};
    bus2 = {16'hC003, 16'hB002, 16'hA001};
    bus3 = '0;
    lat_on[0] = 1; lat_on[1] = 0; lat_on[2] = 0;
    tick(); tick();
    rst1 = 0; rst2 = 0; rst3 = 0;

    // Reset state on all three instances
    chk("rst1_out_valid", 32'(out_valid1), 0);
    chk("rst1_out_data", 32'(od1), 0);
    chk("rst1_in_ready", 32'(in_ready1), 1);
    chk("rst1_err_cnt", 32'(cnt1), 0);
    chk("rst1_err_sticky", 32'(sticky1), 0);
    chk("rst2_out_valid", 32'(out_valid2), 0);
    chk("rst2_in_ready", 32'(in_ready2), 1);
    chk("rst3_out_valid", 32'(out_valid3), 0);
    chk("rst3_in_ready", 32'(in_ready3), 1);
    chk("rst3_err_cnt", 32'(cnt3), 0);
    chk("rst3_err_sticky", 32'(sticky3), 0);

    // T1/T2: table of selects through the 1-stage instance
    vt[0] = '{sel: 2'd0, d: 16'h0001, e: 1'b0, cnt: 8'd0};
    vt[1] = '{sel: 2'd1, d: 16'h0002, e: 1'b0, cnt: 8'd0};
    vt[2] = '{sel: 2'd2, d: 16'h0003, e: 1'b0, cnt: 8'd0};
    vt[3] = '{sel: 2'd3, d: 16'h0000, e: 1'b1, cnt: 8'd1};
    vt[4] = '{sel: 2'd2, d: 16'h0003, e: 1'b0, cnt: 8'd1};
    vt[5] = '{sel: 2'd0, d: 16'h0001, e: 1'b0, cnt: 8'd1};
    for (int i = 0; i < 6; i++) begin
      iv1 = 1;
      sel1 = vt[i].sel;
      tick();
      chk($sformatf("t1_vec%0d_valid", i), 32'(out_valid1), 1);
      chk($sformatf("t1_vec%0d_data", i), 32'(od1), 32'(vt[i].d));
      chk($sformatf("t1_vec%0d_err", i), 32'(out_err1), 32'(vt[i].e));
      chk($sformatf("t1_vec%0d_cnt", i), 32'(cnt1), 32'(vt[i].cnt));
      chk($sformatf("t1_vec%0d_sticky", i), 32'(sticky1), 32'(vt[i].cnt != 0));
    end
    iv1 = 0;
    tick();
    chk("t1_empty_valid", 32'(out_valid1), 0);
    chk("t1_empty_data_held", 32'(od1), 32'h0001);

    // T4: clear colliding with an illegal accept, then saturation
    iv1 = 1; sel1 = 2'd3; clr1 = 1;
    tick();
    clr1 = 0; iv1 = 0;
    chk("t4_clr_collide_sticky", 32'(sticky1), 1);
    chk("t4_clr_collide_cnt", 32'(cnt1), 1);
    clr1 = 1;
    tick();
    clr1 = 0;
    chk("t4_clr_sticky", 32'(sticky1), 0);
    chk("t4_clr_cnt", 32'(cnt1), 0);
    iv1 = 1; sel1 = 2'd3;
    for (int i = 1; i <= 256; i++) begin
      tick();
      if (i == 254 || i == 255 || i == 256)
        chk($sformatf("t4_sat_cnt_after_%0d", i), 32'(cnt1), (i > 255) ? 255 : i);
    end
    iv1 = 0; clr1 = 1;
    tick();
    clr1 = 0;
    chk("t4_final_clr_cnt", 32'(cnt1), 0);

    // T3: 2-stage instance fills while downstream stalls, then drains in order
    base = n_out[1];
    or2 = 0;
    iv2 = 1; sel2 = 2'd0;
    tick();
    chk("t3_ready_after_1", 32'(in_ready2), 1);
    sel2 = 2'd1;
    tick();
    sel2 = 2'd2;
    chk("t3_full_valid", 32'(out_valid2), 1);
    chk("t3_full_data", 32'(od2), 32'hA001);
    chk("t3_full_ready", 32'(in_ready2), 0);
    for (int i = 0; i < 3; i++) begin
      iv2 = (i != 1);
      #1;
      chk($sformatf("t3_held_ready%0d", i), 32'(in_ready2), 0);
      tick();
      chk($sformatf("t3_held_data%0d", i), 32'(od2), 32'hA001);
    end
    or2 = 1;
    #1;
    chk("t3_release_ready", 32'(in_ready2), 1);
    send2(2'd2);
    send2(2'd0);
    for (int n = 0; n < 8; n++) tick();
    chk("t3_beats_out", 32'(n_out[1] - base), 4);
    chk("t3_queue_empty", 32'(sbq[1].size()), 0);

    // T5: reset with two beats in flight, one of them illegal
    send2(2'd3);
    send2(2'd1);
    chk("t5_inflight_valid", 32'(out_valid2), 1);
    chk("t5_pre_cnt", 32'(cnt2), 1);
    rst2 = 1;
    tick();
    chk("t5_out_valid", 32'(out_valid2), 0);
    chk("t5_out_data", 32'(od2), 0);
    chk("t5_out_err", 32'(out_err2), 0);
    chk("t5_err_cnt", 32'(cnt2), 0);
    chk("t5_err_sticky", 32'(sticky2), 0);
    chk("t5_in_ready", 32'(in_ready2), 1);
    rst2 = 0;
    for (int n = 0; n < 4; n++) begin
      tick();
      chk($sformatf("t5_no_stale%0d", n), 32'(out_valid2), 0);
    end

    // T6: random traffic on the 3-stage, 5-input, 32-bit instance
    for (int n = 0; n < 800; n++) begin
      iv3  = ($urandom_range(0, 9) < 7);
      or3  = ($urandom_range(0, 9) < 6);
      sel3 = 3'($urandom_range(0, 7));
      bus3 = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      tick();
    end
    iv3 = 0; or3 = 1;
    for (int n = 0; n < 8; n++) tick();
    chk("t6_random_drained", 32'(sbq[2].size()), 0);
    chk("t6_cnt_nonzero", 32'(cnt3 != 0), 1);

    // Full-rate phase: one beat per clock with exact 3-cycle latency
    lat_on[2] = 1;
    base = n_out[2];
    iv3 = 1;
    for (int n = 0; n < 40; n++) begin
      sel3 = 3'($urandom_range(0, 4));
      bus3 = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      #1;
      chk($sformatf("t6_rate_ready%0d", n), 32'(in_ready3), 1);
      tick();
      if (n >= 2) chk($sformatf("t6_rate_valid%0d", n), 32'(out_valid3), 1);
    end
    iv3 = 0;
    for (int n = 0; n < 8; n++) tick();
    chk("t6_rate_beats_out", 32'(n_out[2] - base), 40);
    chk("t6_rate_drained", 32'(sbq[2].size()), 0);
    lat_on[2] = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
